// File: rtl/dem_su_kien_1111.sv
// Event counter fed by the 1111 detector level output.
// Each rising edge of y_in becomes a one-cycle pulse and one counted event.
// The counter saturates. A sticky alarm is raised once THRESH events have
// accumulated, is held until acknowledged, and is followed by a fixed
// cool-down window during which no new alarm can fire.
//
// state | meaning
// MON   | monitoring, alarm fires when the next count reaches THRESH
// ALARM | alarm held, waiting for ack; events still counted
// COOL  | post-ack cool-down of COOL_CYC cycles, alarm suppressed
module dem_su_kien_1111 #(
    parameter int CW       = 8,
    parameter int THRESH   = 3,
    parameter int COOL_CYC = 4
) (
    input  logic          clk,
    input  logic          rs,
    input  logic          y_in,
    input  logic          clr,
    input  logic          ack,
    output logic          pulse,
    output logic [CW-1:0] count,
    output logic          sat,
    output logic          alarm,
    output logic          cool
);

    typedef enum logic [1:0] {
        MON   = 2'd0,
        ALARM = 2'd1,
        COOL  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] THR       = CW'(THRESH);
    localparam logic [7:0]    COOL_LOAD = 8'(COOL_CYC - 1);

    state_t        state;
    state_t        state_n;
    logic [7:0]    timer;
    logic [7:0]    timer_n;
    logic          y_prev;
    logic          rise;
    logic          ack_ok;
    logic [CW-1:0] cnt_n;

    assign rise   = y_in & ~y_prev;
    assign ack_ok = (state == ALARM) & ack;

    // Next counter value: clear wins, then acknowledge, then saturating increment.
    // A rise coinciding with an accepted ack is intentionally dropped.
    always_comb begin
        cnt_n = count;
        if (clr) begin
            cnt_n = '0;
        end else if (ack_ok) begin
            cnt_n = '0;
        end else if (rise && (count != CNT_MAX)) begin
            cnt_n = count + CNT_ONE;
        end
    end

    // Edge-detect history, event strobe, counter and saturation flag.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            y_prev <= 1'b0;
            pulse  <= 1'b0;
            count  <= '0;
            sat    <= 1'b0;
        end else begin
            y_prev <= y_in;
            pulse  <= rise;
            count  <= cnt_n;
            sat    <= (cnt_n == CNT_MAX);
        end
    end

    // State and cool-down timer registers.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            state <= MON;
            timer <= 8'd0;
        end else begin
            state <= state_n;
            timer <= timer_n;
        end
    end

    // Next-state logic; MON looks at the next count so the alarm lines up
    // with the pulse and the updated count. Unknown codes behave as MON.
    always_comb begin
        state_n = state;
        timer_n = timer;
        case (state)
            ALARM: begin
                if (ack) begin
                    state_n = COOL;
                    timer_n = COOL_LOAD;
                end
            end
            COOL: begin
                if (timer == 8'd0) begin
                    state_n = MON;
                end else begin
                    timer_n = timer - 8'd1;
                end
            end
            default: begin
                state_n = (cnt_n >= THR) ? ALARM : MON;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        alarm = (state == ALARM);
        cool  = (state == COOL);
    end

endmodule

// File: tb/tb_dem_su_kien_1111.sv
// Bench for dem_su_kien_1111: two instances (CW=8 and CW=2), directed
// scenarios followed by random traffic, all checked against an event-level
// reference model kept in plain integers.
module tb_dem_su_kien_1111;

    logic       clk = 1'b0;
    logic       rs;
    logic [1:0] y;
    logic [1:0] clr;
    logic [1:0] ack;
    logic [1:0] pulse;
    logic [1:0] sat;
    logic [1:0] alarm;
    logic [1:0] cool;
    logic [7:0] count_a;
    logic [1:0] count_b;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state, index 0 = wide instance, 1 = narrow instance
    int m_prev[2];
    int m_pulse[2];
    int m_cnt[2];
    int m_alarm[2];
    int m_cool[2];
    int p_max[2];
    int p_thr[2];
    int p_cc[2];

    always #5 clk = ~clk;

    dem_su_kien_1111 #(.CW(8), .THRESH(3), .COOL_CYC(4)) dut_a (
        .clk   (clk),
        .rs    (rs),
        .y_in  (y[0]),
        .clr   (clr[0]),
        .ack   (ack[0]),
        .pulse (pulse[0]),
        .count (count_a),
        .sat   (sat[0]),
        .alarm (alarm[0]),
        .cool  (cool[0])
    );

    dem_su_kien_1111 #(.CW(2), .THRESH(3), .COOL_CYC(4)) dut_b (
        .clk   (clk),
        .rs    (rs),
        .y_in  (y[1]),
        .clr   (clr[1]),
        .ack   (ack[1]),
        .pulse (pulse[1]),
        .count (count_b),
        .sat   (sat[1]),
        .alarm (alarm[1]),
        .cool  (cool[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_prev[i]  = 0;
            m_pulse[i] = 0;
            m_cnt[i]   = 0;
            m_alarm[i] = 0;
            m_cool[i]  = 0;
        end
    endtask

    // one clock of the event-level model: events, counter rules, alarm/cool-down
    task automatic model_step();
        int rise;
        int nc;
        for (int i = 0; i < 2; i++) begin
            if (rs !== 1'b1) begin
                m_prev[i]  = 0;
                m_pulse[i] = 0;
                m_cnt[i]   = 0;
                m_alarm[i] = 0;
                m_cool[i]  = 0;
            end else begin
                rise = (y[i] == 1'b1 && m_prev[i] == 0) ? 1 : 0;
                if (clr[i] == 1'b1)
                    nc = 0;
                else if (m_alarm[i] == 1 && ack[i] == 1'b1)
                    nc = 0;
                else if (rise == 1)
                    nc = (m_cnt[i] < p_max[i]) ? m_cnt[i] + 1 : m_cnt[i];
                else
                    nc = m_cnt[i];
                if (m_alarm[i] == 1) begin
                    if (ack[i] == 1'b1) begin
                        m_alarm[i] = 0;
                        m_cool[i]  = p_cc[i];
                    end
                end else if (m_cool[i] > 0) begin
                    m_cool[i] = m_cool[i] - 1;
                end else if (nc >= p_thr[i]) begin
                    m_alarm[i] = 1;
                end
                m_pulse[i] = rise;
                m_prev[i]  = (y[i] == 1'b1) ? 1 : 0;
                m_cnt[i]   = nc;
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] cnt_obs;
        for (int i = 0; i < 2; i++) begin
            cnt_obs = (i == 0) ? {24'd0, count_a} : {30'd0, count_b};
            chk($sformatf("pulse%0d", i), {31'd0, pulse[i]}, m_pulse[i]);
            chk($sformatf("count%0d", i), cnt_obs, m_cnt[i]);
            chk($sformatf("sat%0d", i),   {31'd0, sat[i]},   (m_cnt[i] == p_max[i]) ? 1 : 0);
            chk($sformatf("alarm%0d", i), {31'd0, alarm[i]}, m_alarm[i]);
            chk($sformatf("cool%0d", i),  {31'd0, cool[i]},  (m_cool[i] > 0) ? 1 : 0);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            check_all();
        end
    endtask

    initial begin
        p_max[0] = 255; p_thr[0] = 3; p_cc[0] = 4;
        p_max[1] = 3;   p_thr[1] = 3; p_cc[1] = 4;
        model_reset();
        rs  = 1'b0;
        y   = 2'b00;
        clr = 2'b00;
        ack = 2'b00;
        tick(2);
        chk("rst_count", {24'd0, count_a}, 0);
        chk("rst_alarm", {31'd0, alarm[0]}, 0);
        rs = 1'b1;
        tick(2);

        // T2: long run gives one event
        y[0] = 1'b1;
        tick(1);
        chk("t2_pulse_rise", {31'd0, pulse[0]}, 1);
        chk("t2_count_rise", {24'd0, count_a}, 1);
        tick(4);
        chk("t2_pulse_held", {31'd0, pulse[0]}, 0);
        chk("t2_count_held", {24'd0, count_a}, 1);
        y[0] = 1'b0;
        tick(2);

        // T3: three separated runs raise the alarm, held until ack
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        y[0] = 1'b1; tick(2); y[0] = 1'b0; tick(2);
        y[0] = 1'b1; tick(2); y[0] = 1'b0; tick(2);
        y[0] = 1'b1; tick(1);
        chk("t3_alarm_fire", {31'd0, alarm[0]}, 1);
        chk("t3_count_fire", {24'd0, count_a}, 3);
        tick(1);
        y[0] = 1'b0;
        tick(10);
        chk("t3_alarm_held", {31'd0, alarm[0]}, 1);
        ack[0] = 1'b1;
        tick(1);
        ack[0] = 1'b0;
        chk("t3_ack_alarm", {31'd0, alarm[0]}, 0);
        chk("t3_ack_cool", {31'd0, cool[0]}, 1);
        chk("t3_ack_count", {24'd0, count_a}, 0);

        // T4: cool-down length and events counted during it
        y[0] = 1'b1; tick(1);
        y[0] = 1'b0; tick(1);
        y[0] = 1'b1; tick(1);
        chk("t4_cool_last", {31'd0, cool[0]}, 1);
        y[0] = 1'b0; tick(1);
        chk("t4_cool_end", {31'd0, cool[0]}, 0);
        chk("t4_count2", {24'd0, count_a}, 2);
        chk("t4_no_alarm", {31'd0, alarm[0]}, 0);
        y[0] = 1'b1; tick(1);
        chk("t4_alarm_third", {31'd0, alarm[0]}, 1);
        y[0] = 1'b0; tick(1);
        ack[0] = 1'b1; tick(1);
        ack[0] = 1'b0; tick(5);

        // T5: clear beats a simultaneous rise
        y[0] = 1'b1; tick(1); y[0] = 1'b0; tick(1);
        y[0] = 1'b1; tick(1); y[0] = 1'b0; tick(1);
        chk("t5_count2", {24'd0, count_a}, 2);
        y[0] = 1'b1; clr[0] = 1'b1;
        tick(1);
        chk("t5_clr_count", {24'd0, count_a}, 0);
        chk("t5_clr_pulse", {31'd0, pulse[0]}, 1);
        y[0] = 1'b0; clr[0] = 1'b0;
        tick(1);
        chk("t5_no_alarm", {31'd0, alarm[0]}, 0);

        // T1: asynchronous reset while alarmed, y high at release
        for (int r = 0; r < 3; r++) begin
            y[0] = 1'b1; tick(1); y[0] = 1'b0; tick(1);
        end
        chk("t1_alarm_pre", {31'd0, alarm[0]}, 1);
        #3 rs = 1'b0;
        #1;
        chk("t1_async_alarm", {31'd0, alarm[0]}, 0);
        chk("t1_async_count", {24'd0, count_a}, 0);
        chk("t1_async_pulse", {31'd0, pulse[0]}, 0);
        chk("t1_async_cool", {31'd0, cool[0]}, 0);
        model_reset();
        y[0] = 1'b1;
        tick(1);
        rs = 1'b1;
        tick(1);
        chk("t1_release_pulse", {31'd0, pulse[0]}, 1);
        chk("t1_release_count", {24'd0, count_a}, 1);
        y[0] = 1'b0;
        tick(1);

        // T6: narrow counter saturates, clear keeps the alarm
        for (int r = 0; r < 5; r++) begin
            y[1] = 1'b1; tick(1); y[1] = 1'b0; tick(1);
        end
        chk("t6_count_sat", {30'd0, count_b}, 3);
        chk("t6_sat", {31'd0, sat[1]}, 1);
        chk("t6_alarm", {31'd0, alarm[1]}, 1);
        clr[1] = 1'b1;
        tick(1);
        clr[1] = 1'b0;
        chk("t6_clr_count", {30'd0, count_b}, 0);
        chk("t6_clr_sat", {31'd0, sat[1]}, 0);
        chk("t6_clr_alarm", {31'd0, alarm[1]}, 1);
        ack[1] = 1'b1; tick(1);
        ack[1] = 1'b0; tick(5);

        // random traffic on both instances
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 2; i++) begin
                y[i]   = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
                clr[i] = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
                ack[i] = ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
            end
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
